// File: rtl/ps2_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event_gen
// Description : Turns a vector of level key inputs into paced toggle events
//               on the 11-bit ps2_key bus {toggle, pressed, code[8:0]}.
//               Pipeline: sample register -> lowest-index change scanner ->
//               event FIFO -> gap-paced emitter.
// Ports       : clk_sys   - system clock, rising edge
//               reset     - synchronous active-high reset
//               enable    - scanner enable; low freezes event generation
//               key_state - key levels, 1 = pressed
//               key_code  - flat table, key i code = key_code[9i+8:9i]
//               ps2_key   - event bus, bit 10 toggles once per event
//               busy      - changes pending, FIFO non-empty or gap running
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_gen #(
    parameter int NKEYS      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NKEYS-1:0]     key_state,
    input  logic [9*NKEYS-1:0]   key_code,
    output logic [10:0]          ps2_key,
    output logic                 busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(GAP);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Sample and scanner state
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] r_ks_q;
    logic [NKEYS-1:0] r_reported;
    logic [NKEYS-1:0] w_pending;
    logic [NKEYS-1:0] w_sel_oh;
    logic [9:0]       w_wdata;
    logic             w_wr;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic          w_full;
    logic          w_empty;
    logic [9:0]    w_head;

    // ------------------------------------------------------------------
    // Emitter state
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_rd;
    logic [10:0]     r_ps2_key;

    // Level-based difference: a key whose level differs from what was last
    // reported is pending, so a change can never be lost while stalled.
    assign w_pending = r_ks_q ^ r_reported;

    // Lowest pending index wins: iterate downwards so the last hit is lowest.
    always_comb begin
        w_sel_oh = '0;
        w_wdata  = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
                w_wdata     = {r_ks_q[i], key_code[9*i +: 9]};
            end
        end
    end

    // Full blocks the write even when a pop happens in the same cycle.
    assign w_wr    = enable & ~w_full & (|w_pending);
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_head  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ks_q     <= '0;
            r_reported <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_ks_q <= key_state;
            if (w_wr) begin
                // Pending bit means reported != ks_q, so toggling aligns them.
                r_reported <= r_reported ^ w_sel_oh;
                r_wptr     <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_sys) begin
        if (w_wr) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Emitter: toggle at edge T enters WAIT with cnt=0; leaving WAIT at
    // edge T+GAP-1 lets the next toggle land exactly at T+GAP.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_rd        = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (r_cnt == c_CW'(GAP - 2)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ps2_key <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_rd) begin
                r_ps2_key <= {~r_ps2_key[10], w_head};
            end
        end
    end

    assign ps2_key = r_ps2_key;
    assign busy    = (|w_pending) | ~w_empty | (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_event_gen
// Description : Scoreboard bench for ps2_key_event_gen. Expected events
//               (value and arrival cycle) are queued when keys are driven
//               and compared when bit 10 of ps2_key toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_gen;

    localparam int NKEYS      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP        = 16;

    typedef struct {
        logic [10:0] val;
        int          cyc;
    } exp_t;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic                 enable  = 1'b1;
    logic [NKEYS-1:0]     key_state = '0;
    logic [9*NKEYS-1:0]   key_code  = '0;
    logic [10:0]          ps2_key;
    logic                 busy;

    exp_t  sb[$];
    int    cyc    = 0;
    int    n_chk  = 0;
    int    n_pass = 0;
    logic  tb_tog = 1'b0;
    logic  mon_en = 1'b0;
    logic  mon_prev = 1'b0;

    ps2_key_event_gen #(
        .NKEYS      (NKEYS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP        (GAP)
    ) u_dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .key_state (key_state),
        .key_code  (key_code),
        .ps2_key   (ps2_key),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic set_code(input int i, input logic [8:0] c);
        key_code[9*i +: 9] = c;
    endtask

    // Model of the bus: each event flips the bench's own toggle copy.
    task automatic push(input logic pressed, input logic [8:0] code, input int at);
        exp_t e;
        e.val  = {~tb_tog, pressed, code};
        e.cyc  = at;
        tb_tog = ~tb_tog;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < GAP * 12 + 20) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: sample away from the active edge; a bit-10 change is an event.
    always @(negedge clk_sys) begin : mon
        exp_t e;
        if (mon_en && (ps2_key[10] !== mon_prev)) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("evt_value", 32'(ps2_key), 32'(e.val));
                chk("evt_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        mon_prev = ps2_key[10];
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int e0;
        int e1;
        logic [8:0] codes [NKEYS];
        codes[0] = 9'h01C; codes[1] = 9'h032; codes[2] = 9'h021; codes[3] = 9'h023;
        codes[4] = 9'h114; codes[5] = 9'h02B; codes[6] = 9'h034; codes[7] = 9'h033;

        // Reset for two cycles with keys idle.
        tick(2);
        reset = 1'b0;
        chk("rst_ps2_key", 32'(ps2_key), 32'h000);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(1);
        chk("rst_ps2_key_hold", 32'(ps2_key), 32'h000);
        chk("rst_busy_hold", 32'(busy), 32'd0);
        mon_en = 1'b1;
        tick(2);

        // Single press / release.
        set_code(0, 9'h075);
        e0 = cyc;
        key_state[0] = 1'b1;
        push(1'b1, 9'h075, e0 + 3);
        tick(1);
        chk("busy_pending", 32'(busy), 32'd1);
        tick(39);
        key_state[0] = 1'b0;
        push(1'b0, 9'h075, e0 + 43);
        tick(3 + GAP);
        chk("single_busy_low", 32'(busy), 32'd0);
        chk("single_sb_empty", 32'(sb.size()), 32'd0);
        tick(4);

        // Simultaneous presses: emitted in ascending index order.
        set_code(0, 9'h06B);
        set_code(2, 9'h074);
        set_code(5, 9'h029);
        e0 = cyc;
        key_state[5] = 1'b1;
        key_state[2] = 1'b1;
        key_state[0] = 1'b1;
        push(1'b1, 9'h06B, e0 + 3);
        push(1'b1, 9'h074, e0 + 3 + GAP);
        push(1'b1, 9'h029, e0 + 3 + 2 * GAP);
        drain("simul_drain");
        tick(GAP);
        key_state = '0;
        push(1'b0, 9'h06B, cyc + 3);
        push(1'b0, 9'h074, cyc + 3 + GAP);
        push(1'b0, 9'h029, cyc + 3 + 2 * GAP);
        drain("simul_rel_drain");
        tick(GAP + 4);
        chk("simul_busy_low", 32'(busy), 32'd0);

        // Enable gating.
        for (int i = 0; i < NKEYS; i++) set_code(i, codes[i]);
        enable = 1'b0;
        key_state[3] = 1'b1;
        tick(5);
        key_state[3] = 1'b0;
        tick(10);
        chk("gate_no_event", 32'(ps2_key[9:0]), 32'h029);
        key_state[4] = 1'b1;
        tick(8);
        chk("gate_busy_pending", 32'(busy), 32'd1);
        e1 = cyc;
        enable = 1'b1;
        push(1'b1, 9'h114, e1 + 2);
        drain("gate_drain");
        tick(GAP);
        key_state[4] = 1'b0;
        push(1'b0, 9'h114, cyc + 3);
        drain("gate_rel_drain");
        tick(GAP + 4);

        // FIFO-full stall: all keys at once.
        e0 = cyc;
        key_state = '1;
        for (int i = 0; i < NKEYS; i++) push(1'b1, codes[i], e0 + 3 + i * GAP);
        tick(1);
        while (cyc <= e0 + 3 + (NKEYS - 1) * GAP) begin
            chk("full_busy", 32'(busy), 32'd1);
            tick(1);
        end
        drain("full_drain");
        tick(GAP);
        key_state = '0;
        e0 = cyc;
        for (int i = 0; i < NKEYS; i++) push(1'b0, codes[i], e0 + 3 + i * GAP);
        drain("full_rel_drain");
        tick(GAP + 4);
        chk("full_busy_low", 32'(busy), 32'd0);

        // Reset during the second WAIT with all keys held.
        e0 = cyc;
        key_state = '1;
        for (int i = 0; i < NKEYS; i++) push(1'b1, codes[i], e0 + 3 + i * GAP);
        tick(3 + GAP + 3);
        chk("mid_sb_two_left_out", 32'(sb.size()), 32'(NKEYS - 2));
        reset  = 1'b1;
        mon_en = 1'b0;
        tick(1);
        reset = 1'b0;
        sb.delete();
        tb_tog = 1'b0;
        chk("mid_rst_ps2_key", 32'(ps2_key), 32'h000);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        e0 = cyc;
        for (int i = 0; i < NKEYS; i++) push(1'b1, codes[i], e0 + 3 + i * GAP);
        tick(1);
        mon_en = 1'b1;
        drain("mid_drain");
        tick(2 * GAP);
        chk("mid_no_extra", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
